// File: rtl/tpu_pkg.sv
// Shared definitions for the tpu_mmu_stream systolic matrix-multiply engine.
//   state_t    : controller states
//   acc_width  : default exact accumulator width for an N x N job of DW-bit operands
//   rm_idx     : row-major flat index of element [r][c] in an n x n matrix
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_A,
    COMPUTE,
    DRAIN
  } state_t;

  // 2*DW bits per product, plus enough headroom to sum n of them and keep a sign bit.
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  function automatic int rm_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/tpu_pe.sv
// One processing element of the output-stationary systolic array.
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : synchronous clear of accumulator and pass-through registers
//   en           : accumulate enable (high while the array is computing)
//   a_in, w_in   : operands arriving from the west / north
//   a_out, w_out : operands registered one cycle and forwarded east / south
//   acc          : running sum of a_in * w_in
module tpu_pe #(
  parameter int DW     = 8,
  parameter int ACC_W  = 18,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [DW-1:0]    a_in,
  input  logic [DW-1:0]    w_in,
  output logic [DW-1:0]    a_out,
  output logic [DW-1:0]    w_out,
  output logic [ACC_W-1:0] acc
);

  logic            sgn;
  logic [2*DW-1:0] a_ext;
  logic [2*DW-1:0] w_ext;
  logic [2*DW-1:0] prod;
  logic [ACC_W-1:0] prod_ext;

  assign sgn   = (SIGNED != 0);
  assign a_ext = {{DW{sgn & a_in[DW-1]}}, a_in};
  assign w_ext = {{DW{sgn & w_in[DW-1]}}, w_in};
  // Low 2*DW bits of the product of the extended operands are the exact
  // signed (or unsigned) DW x DW product.
  assign prod     = a_ext * w_ext;
  assign prod_ext = {{(ACC_W - 2*DW){sgn & prod[2*DW-1]}}, prod};

  // NOTE: state registers use non-blocking assignments so every PE samples its
  // neighbours' previous-cycle values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      w_out <= '0;
      acc   <= '0;
    end else if (clear) begin
      a_out <= '0;
      w_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      w_out <= w_in;
      if (en) acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/tpu_mmu_stream.sv
// N x N output-stationary systolic matrix multiplier, C = A x W.
//   clk, rst            : clock, asynchronous active-high reset
//   start, keep_w       : begin a job (IDLE only); keep_w reuses stored weights
//   in_valid/in_ready   : operand stream, W then A, row-major, DW bits
//   out_valid/out_ready : result stream, C row-major, ACC_W bits
//   busy                : high outside IDLE
//   done                : one-cycle pulse after the last result is accepted
module tpu_mmu_stream
  import tpu_pkg::*;
#(
  parameter int N      = 2,
  parameter int DW     = 8,
  parameter int ACC_W  = acc_width(N, DW),
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             keep_w,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             done
);

  localparam int NN = N * N;
  localparam int CW = $clog2(NN);
  localparam int TW = $clog2(3 * N);
  localparam logic [CW-1:0] LAST_E = CW'(NN - 1);
  localparam logic [TW-1:0] LAST_T = TW'(3 * N - 3);

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   t_cnt;
  logic            w_loaded;
  logic            in_fire, out_fire, last_e;
  logic            clear, en;

  logic [DW-1:0]    w_reg  [NN];
  logic [DW-1:0]    a_reg  [NN];
  logic [DW-1:0]    feed_a [N];
  logic [DW-1:0]    feed_w [N];
  logic [DW-1:0]    a_e    [N][N];
  logic [DW-1:0]    w_s    [N][N];
  logic [ACC_W-1:0] acc    [NN];

  assign in_ready  = (state == LOAD_W) || (state == LOAD_A);
  assign out_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_e    = (cnt == LAST_E);
  assign clear     = (state == LOAD_A) && in_fire && last_e;
  assign en        = (state == COMPUTE);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = (keep_w && w_loaded) ? LOAD_A : LOAD_W;
      LOAD_W:  if (in_fire && last_e) state_n = LOAD_A;
      LOAD_A:  if (in_fire && last_e) state_n = COMPUTE;
      COMPUTE: if (t_cnt == LAST_T) state_n = DRAIN;
      DRAIN:   if (out_fire && last_e) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One element counter serves loading and draining; it wraps to zero after
  // the last element of each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      t_cnt    <= '0;
      w_loaded <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state == DRAIN) && out_fire && last_e;
      if (in_fire || out_fire) cnt <= last_e ? '0 : cnt + 1'b1;
      if (state == COMPUTE) t_cnt <= (t_cnt == LAST_T) ? '0 : t_cnt + 1'b1;
      if ((state == LOAD_W) && in_fire && last_e) w_loaded <= 1'b1;
    end
  end

  // NOTE: the operand stores are plain storage with no reset; they are always
  // fully written before being read, and keeping reset off them keeps them RAM-friendly.
  always_ff @(posedge clk) begin
    if (in_fire && (state == LOAD_W)) w_reg[cnt] <= in_data;
    if (in_fire && (state == LOAD_A)) a_reg[cnt] <= in_data;
  end

  // Skew feeders: at compute cycle t, row lane i carries A[i][t-i] and column
  // lane j carries W[t-j][j]; lanes outside their window carry zero.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      feed_a[i] = '0;
      feed_w[i] = '0;
      if (state == COMPUTE) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t_cnt) == i + k) begin
            feed_a[i] = a_reg[rm_idx(i, k, N)];
            feed_w[i] = w_reg[rm_idx(k, i, N)];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_in_ij, w_in_ij;
      if (j == 0) begin : g_a_edge
        assign a_in_ij = feed_a[i];
      end else begin : g_a_chain
        assign a_in_ij = a_e[i][j-1];
      end
      if (i == 0) begin : g_w_edge
        assign w_in_ij = feed_w[j];
      end else begin : g_w_chain
        assign w_in_ij = w_s[i-1][j];
      end
      tpu_pe #(.DW(DW), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (en),
        .a_in  (a_in_ij),
        .w_in  (w_in_ij),
        .a_out (a_e[i][j]),
        .w_out (w_s[i][j]),
        .acc   (acc[rm_idx(i, j, N)])
      );
    end
  end

  // The east and south edges of the array have no consumer.
  logic edge_unused;
  always_comb begin
    edge_unused = 1'b0;
    for (int i = 0; i < N; i++) edge_unused = edge_unused ^ (^a_e[i][N-1]) ^ (^w_s[N-1][i]);
  end

  // cnt only changes on a transfer, so the selected result holds under back-pressure.
  always_comb begin
    out_data = '0;
    if (state == DRAIN) out_data = acc[cnt];
  end

endmodule

// File: doc/tpu_mmu_stream.md
Name: tpu_mmu_stream

Overview:
Parametrised N×N output-stationary systolic matrix-multiply engine computing C = A × W. It is the generalised successor of the fixed 2×2 TinyTapeout TPU datapath. Operands stream in and results stream out over valid/ready byte-style channels, so the block sits directly behind the pin-level wrapper or a host FSM. It adds a weight-reuse mode, signed/unsigned selection and back-pressured result drain.

Parameters:
N, 2, array dimension; matrices are N×N, N ≥ 2.
DW, 8, operand width in bits.
ACC_W, 2*DW+$clog2(N)+1, accumulator/result width; exact, never overflows.
SIGNED, 1, 1 = two's-complement operands and results, 0 = unsigned.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin job; honoured only in IDLE
keep_w  in  1  sampled with start; 1 = reuse stored weights and skip LOAD_W
in_valid  in  1  operand valid
in_ready  out  1  operand ready
in_data  in  DW  operand, row-major order
out_valid  out  1  result valid
out_ready  in  1  result ready
out_data  out  ACC_W  result element, row-major order, sign-extended when SIGNED=1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: last result accepted

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
- Reset clears accumulators, element counters and w_loaded. Stored weights need not be cleared.
- A transfer occurs on any edge where valid && ready. Data is sampled only on transfer.
- IDLE: in_ready=0. On start:
  - keep_w=1 and w_loaded=1 → LOAD_A.
  - Otherwise → LOAD_W. keep_w with no weights loaded since reset falls back to LOAD_W.
- LOAD_W: in_ready=1. Accept exactly N*N elements W[r][c], row-major, into the weight register. After the last one, set w_loaded=1 and go to LOAD_A.
- LOAD_A: in_ready=1. Accept exactly N*N elements A[r][c], row-major. After the last one, clear all accumulators and go to COMPUTE.
- COMPUTE: in_ready=0. Lasts exactly 3N-2 cycles.
  - Row i of A enters the array skewed by i cycles. Column j of W is skewed by j cycles.
  - PE(i,j) accumulates A[i][k]*W[k][j].
  - Idle input lanes feed zero.
  - Then go to DRAIN.
- DRAIN:
  - out_valid=1 with C[0][0] on the first DRAIN cycle.
  - out_data is held stable while out_valid && !out_ready.
  - On each transfer, advance row-major to the next element.
  - After C[N-1][N-1] is transferred: out_valid=0 the next cycle, done=1 for one cycle, state=IDLE.
- done and IDLE coincide. A start in that cycle is accepted.
- start, keep_w and in_valid outside their accepting states are ignored. There is no error flag.
- Arithmetic: products are 2*DW bits, signed or unsigned per SIGNED, extended to ACC_W before accumulation.
- Minimum job latency, start to done, with in_valid and out_ready held high: 1 + 2N² (or N² with keep_w) + (3N-2) + N² cycles.

Decomposition:
- Package tpu_pkg holds:
  - state enum {IDLE, LOAD_W, LOAD_A, COMPUTE, DRAIN};
  - the default ACC_W width function;
  - the row-major index helper.
- One sub-module tpu_pe (parameters DW, ACC_W, SIGNED):
  - registered a/w pass-through, east and south;
  - clear input and multiply-accumulate.
- The top holds the FSM, counters, operand registers, skew feeders and the output mux.

Test Plan:
1. Basic job: N=2, SIGNED=1, keep_w=0. W=[[5,6],[7,8]], A=[[1,2],[3,4]], out_ready=1 → out_data stream 19,22,43,50; done pulses once; busy falls the same cycle.
2. Signed corners: all A=-128, all W=-128 → four results of 32768. Then A=-128, W=127 → four results of -32512, sign-extended.
3. Weight reuse: after test 1, start with keep_w=1 and A=identity → in_ready stays high for only 4 transfers; results 5,6,7,8.
4. Back-pressure: toggle out_ready randomly and drop in_valid every other cycle → identical results to test 1. out_data is stable while stalled. No element is lost or duplicated.
5. Reset mid-COMPUTE: assert rst for 1 cycle → all outputs 0 immediately. Then start with keep_w=1 → falls back to LOAD_W; the full job gives the correct results.
6. Back-to-back: assert start in the done cycle → the next job begins without an idle gap, verified for N=4 against a reference model with random signed operands.
